uart_rx_param: RTL

Parametrised UART receiver that generalises the team's fixed 8N1 receiver to configurable data width, oversampling ratio, parity mode and stop-bit count. It adds input synchronisation, false-start rejection, and parity and framing error reporting. It sits between the `rx` pad and the byte-consuming logic, and is driven by the shared baud-tick generator running at OVERSAMPLE × baud rate.

---
 rtl/uart_rx_param_if.sv | 29 ++
 rtl/uart_rx_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param_if.sv
// Receive-side bundle of the parametrised UART receiver: the completed-frame
// strobe, the received word and its error flags, plus the busy indicator.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_done_tick;
    logic [DATA_BITS-1:0] data_out;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    // The receiver drives the bundle.
    modport master (
        output rx_done_tick,
        output data_out,
        output parity_err,
        output frame_err,
        output busy
    );

    // The word consumer only observes it.
    modport slave (
        input rx_done_tick,
        input data_out,
        input parity_err,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, oversampling ratio,
// parity mode and stop-bit count. rx is synchronised, false starts are
// rejected at the start-bit midpoint, and parity/framing errors are reported
// alongside the word. Outputs only change on the final stop sample.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              rx,
    uart_rx_param_if.master   rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] MID_CNT  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_CNT = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_END = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_END = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state, state_n;
    logic [1:0]           sync;
    logic                 rxs;
    logic [TW-1:0]        tick, tick_n;
    logic [BW-1:0]        bitc, bitc_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_flag, par_flag_n;
    logic                 frm_flag, frm_flag_n;
    logic                 done_n;

    assign rxs = sync[1];

    // Two-stage synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end

    // Next-state logic: framing FSM, sample counters, shift register and flags.
    always_comb begin
        state_n    = state;
        tick_n     = tick;
        bitc_n     = bitc;
        shreg_n    = shreg;
        par_flag_n = par_flag;
        frm_flag_n = frm_flag;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                // Ticks are ignored here so a coincident tick never pre-counts.
                if (!rxs) begin
                    tick_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick == MID_CNT) begin
                        if (rxs) begin
                            state_n = IDLE;   // glitch, not a start bit
                        end else begin
                            tick_n     = '0;
                            bitc_n     = '0;
                            par_flag_n = 1'b0;
                            frm_flag_n = 1'b0;
                            state_n    = DATA;
                        end
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick == LAST_CNT) begin
                        tick_n  = '0;
                        shreg_n = {rxs, shreg[DATA_BITS-1:1]};
                        if (bitc == DATA_END) begin
                            bitc_n  = '0;
                            state_n = (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bitc_n = bitc + BW'(1);
                        end
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
            end
            PAR: begin
                if (baud_tick) begin
                    if (tick == LAST_CNT) begin
                        tick_n = '0;
                        // Odd mode wants an overall XOR of 1, even mode of 0.
                        if (PARITY == 1) par_flag_n = ~(^shreg ^ rxs);
                        else             par_flag_n = ^shreg ^ rxs;
                        state_n = STOP;
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick == LAST_CNT) begin
                        tick_n = '0;
                        if (!rxs) frm_flag_n = 1'b1;
                        if (bitc == STOP_END) begin
                            // Leave at the stop midpoint so a back-to-back
                            // start edge is seen on the very next clk.
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            bitc_n = bitc + BW'(1);
                        end
                    end else begin
                        tick_n = tick + TW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and working registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tick     <= '0;
            bitc     <= '0;
            shreg    <= '0;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else begin
            state    <= state_n;
            tick     <= tick_n;
            bitc     <= bitc_n;
            shreg    <= shreg_n;
            par_flag <= par_flag_n;
            frm_flag <= frm_flag_n;
        end
    end

    // Output register: loads only on the final stop sample so consumers
    // never see a half-built word; the strobe lines up with the new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_if.rx_done_tick <= 1'b0;
            rx_if.data_out     <= '0;
            rx_if.parity_err   <= 1'b0;
            rx_if.frame_err    <= 1'b0;
        end else begin
            rx_if.rx_done_tick <= done_n;
            if (done_n) begin
                rx_if.data_out   <= shreg;
                rx_if.parity_err <= par_flag;
                rx_if.frame_err  <= frm_flag_n;
            end
        end
    end

    assign rx_if.busy = (state != IDLE);
endmodule
